gray_cnt_gen: RTL and testbench

Synchronous gray-code counter that produces the 4-bit (parameterisable) gray word consumed by the `g_b` gray-to-binary converter. It keeps an internal binary count and supports enable, up/down stepping, synchronous load and wrap detection. Its registered gray output is the stimulus and operand source for the downstream `g_b` stage. It also exports the matching binary count as a golden reference for checking `g_b`.

---
 rtl/gray_cnt_gen.sv | 37 +++
 tb/tb_gray_cnt_gen.sv | 95 +++++++++
 2 files changed

// File: rtl/gray_cnt_gen.sv
// gray_cnt_gen: binary counter with registered gray output, load, up/down stepping and wrap pulse
module gray_cnt_gen #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] bin_ref,
  output logic             wrap,
  output logic             valid
);
  logic [WIDTH-1:0] cnt, nxt;
  logic             nwrap;
  always_comb begin
    nxt   = load ? load_val : en ? (up ? cnt + 1'b1 : cnt - 1'b1) : cnt;
    nwrap = !load && en && (up ? &cnt : ~|cnt);
  end
  // g is derived from the next count so it stays in lockstep with cnt
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      g     <= '0;
      wrap  <= 1'b0;
      valid <= 1'b0;
    end else begin
      cnt   <= nxt;
      g     <= nxt ^ (nxt >> 1);
      wrap  <= nwrap;
      valid <= 1'b1;
    end
  end
  assign bin_ref = cnt;
endmodule

// File: tb/tb_gray_cnt_gen.sv
// tb_gray_cnt_gen: randomized scoreboard bench for gray_cnt_gen against an arithmetic model
module tb_gray_cnt_gen;
  localparam int W = 4;
  localparam int N = 1 << W;
  logic clk = 0, rst = 0, en = 0, up = 0, load = 0;
  logic [W-1:0] load_val = '0, g, bin_ref;
  logic wrap, valid;
  int total = 0, bad = 0;
  typedef struct {
    logic [W-1:0] g, b;
    logic w, v;
    int kind;
  } exp_t;
  exp_t q[$];
  int m = 0;
  gray_cnt_gen #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .g(g), .bin_ref(bin_ref), .wrap(wrap), .valid(valid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // one cycle of stimulus; the model predicts the outputs after the coming edge
  task automatic cyc(input logic r, input logic l, input int lv, input logic e, input logic u);
    exp_t x;
    @(negedge clk);
    rst = r; load = l; load_val = W'(lv); en = e; up = u;
    x.w = 0; x.v = 1; x.kind = 0;
    if (r) begin m = 0; x.v = 0; end
    else if (l) m = lv % N;
    else if (e) begin
      x.kind = 1;
      if (u) begin x.w = (m == N - 1); m = (m + 1) % N; end
      else begin x.w = (m == 0); m = (m + N - 1) % N; end
    end else x.kind = 2;
    x.b = W'(m);
    x.g = W'(m ^ (m / 2));
    q.push_back(x);
  endtask
  initial begin : monitor
    exp_t x;
    logic [W-1:0] pg;
    pg = '0;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        x = q.pop_front();
        chk("g", g, x.g);
        chk("bin_ref", bin_ref, x.b);
        chk("wrap", wrap, x.w);
        chk("valid", valid, x.v);
        if (x.kind == 1) chk("step_onebit", $countones(g ^ pg), 1);
        if (x.kind == 2) chk("hold_nobit", $countones(g ^ pg), 0);
        pg = g;
      end
    end
  end
  initial begin
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) cyc(0, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 9, 1, 0);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 1, 6, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 1, 12, 0, 0);
    cyc(1, 1, 5, 1, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1);
    for (int i = 0; i < 100; i++) cyc(0, 0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 60; i++)
      cyc(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 5) == 0), $urandom_range(0, N - 1),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    cyc(0, 1, 15, 0, 0);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 0);
    @(posedge clk);
    #3;
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
